// File: rtl/adc_scan_sequencer_pkg.sv
// rtl/adc_scan_sequencer_pkg.sv - shared FSM encodings, counter width and width helper
package adc_scan_sequencer_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  // Channel-select ports stay at least one bit wide even for a single channel.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: lowest requester at or after ptr wins
module rr_arbiter #(
  parameter int N_CH = 4,
  parameter int SW   = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [SW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [N_CH-1:0] req_rot;
  logic [SW-1:0]   offset;
  logic [SW:0]     sum;

  always_comb begin
    // Rotate so the pointer channel lands at bit 0; the first set bit is the winner's offset.
    req_rot   = N_CH'({req, req} >> ptr);
    offset    = '0;
    grant_any = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset    = SW'(i);
        grant_any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (SW + 1)'(N_CH)) begin
      sum = sum - (SW + 1)'(N_CH);
    end
    grant_idx = sum[SW-1:0];
    grant     = grant_any ? (N_CH'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - round-robin scan of N_CH requesters through one shared mux + SAR ADC
module adc_scan_sequencer
  import adc_scan_sequencer_pkg::*;
#(
  parameter int BITS   = 4,
  parameter int N_CH   = 4,
  parameter int SETTLE = 2,
  parameter int TD     = 1,
  localparam int SW    = sel_width(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] ack,
  output logic [SW-1:0]   mux_sel,
  output logic            adc_clk,
  input  logic [BITS-1:0] adc_dout,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [BITS-1:0] res_data,
  output logic [SW-1:0]   res_ch,
  output logic            busy
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CNT_W-1:0] TD_LAST     = CNT_W'(TD);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     ptr_q, ptr_d;
  logic [SW-1:0]     mux_sel_q, mux_sel_d;
  logic [N_CH-1:0]   ack_q, ack_d;
  logic              adc_clk_q, adc_clk_d;
  logic              res_valid_q, res_valid_d;
  logic [BITS-1:0]   res_data_q, res_data_d;
  logic [SW-1:0]     res_ch_q, res_ch_d;
  logic              busy_q, busy_d;

  logic [N_CH-1:0]   gnt;
  logic [SW-1:0]     gnt_idx;
  logic              gnt_any;
  logic [SW:0]       ptr_inc;

  rr_arbiter #(.N_CH(N_CH), .SW(SW)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (gnt),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  assign ptr_inc = {1'b0, gnt_idx} + (SW + 1)'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    mux_sel_d   = mux_sel_q;
    ack_d       = '0;
    adc_clk_d   = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          mux_sel_d = gnt_idx;
          ack_d     = gnt;
          ptr_d     = (ptr_inc == (SW + 1)'(N_CH)) ? '0 : ptr_inc[SW-1:0];
          cnt_d     = '0;
          state_d   = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SAMPLE: begin
        adc_clk_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // TD+1 cycles are counted after the cycle in which the sample pulse is high.
        if (!adc_clk_q) begin
          if (cnt_q == TD_LAST) begin
            res_data_d  = adc_dout;
            res_ch_d    = mux_sel_q;
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      mux_sel_q   <= '0;
      ack_q       <= '0;
      adc_clk_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      mux_sel_q   <= mux_sel_d;
      ack_q       <= ack_d;
      adc_clk_q   <= adc_clk_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      busy_q      <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign mux_sel   = mux_sel_q;
  assign adc_clk   = adc_clk_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ch    = res_ch_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - randomized bench for adc_scan_sequencer against a transaction model
module tb_adc_scan_sequencer;

  localparam int BITS = 4;
  localparam int N    = 4;
  localparam int S_A  = 2;
  localparam int TD_A = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_a, res_ready_a, adc_clk_a, res_valid_a, busy_a;
  logic [N-1:0]    req_a, ack_a;
  logic [1:0]      mux_sel_a, res_ch_a;
  logic [BITS-1:0] adc_dout_a, res_data_a;

  logic            rst_b, res_ready_b, adc_clk_b, res_valid_b, busy_b;
  logic [N-1:0]    req_b, ack_b;
  logic [1:0]      mux_sel_b, res_ch_b;
  logic [BITS-1:0] adc_dout_b, res_data_b;

  adc_scan_sequencer #(.BITS(BITS), .N_CH(N), .SETTLE(S_A), .TD(TD_A)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .ack(ack_a), .mux_sel(mux_sel_a),
    .adc_clk(adc_clk_a), .adc_dout(adc_dout_a), .res_valid(res_valid_a),
    .res_ready(res_ready_a), .res_data(res_data_a), .res_ch(res_ch_a), .busy(busy_a)
  );

  adc_scan_sequencer #(.BITS(BITS), .N_CH(N), .SETTLE(0), .TD(0)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .ack(ack_b), .mux_sel(mux_sel_b),
    .adc_clk(adc_clk_b), .adc_dout(adc_dout_b), .res_valid(res_valid_b),
    .res_ready(res_ready_b), .res_data(res_data_b), .res_ch(res_ch_b), .busy(busy_b)
  );

  real vin [N] = '{0.6, 0.25, 0.9, 0.1};
  int total = 0;
  int bad   = 0;
  int ptr_m = 0;

  function automatic int adc_code(input real v);
    int c;
    c = int'($floor(v * real'(1 << BITS)));
    if (c > (1 << BITS) - 1) c = (1 << BITS) - 1;
    return c;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] t;
    for (int off = 0; off < N; off++) begin
      t = r >> ((p + off) % N);
      if (t[0]) return (p + off) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ADC models: sample on the adc_clk pulse, drive the inverted code until the delay expires.
  int cd_a = 0;
  int cd_b = 0;
  logic [BITS-1:0] pend_a, pend_b;
  always @(negedge clk) begin
    if (adc_clk_a) begin
      pend_a     = BITS'(adc_code(vin[mux_sel_a]));
      cd_a       = TD_A;
      adc_dout_a = (TD_A == 0) ? pend_a : ~pend_a;
    end else if (cd_a > 0) begin
      cd_a--;
      if (cd_a == 0) adc_dout_a = pend_a;
    end
  end
  always @(negedge clk) begin
    if (adc_clk_b) begin
      pend_b     = BITS'(adc_code(vin[mux_sel_b]));
      cd_b       = 0;
      adc_dout_b = pend_b;
    end
  end

  task automatic do_conv(input logic [N-1:0] r, input int hold, input bit drop, input string tag);
    int exp_ch, n, k, clk_pos, pulses, acks;
    logic [BITS-1:0] d0;
    logic [1:0] c0;
    bit unstable;
    exp_ch = pick(r, ptr_m);
    req_a = r;
    res_ready_a = (hold == 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_a == '0 && n < 40);
    if (ack_a == '0) begin
      chk({tag, "_ack_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_ack"}, ack_a, N'(1) << exp_ch);
    chk({tag, "_mux_sel"}, mux_sel_a, exp_ch);
    chk({tag, "_busy"}, busy_a, 1);
    ptr_m = (exp_ch + 1) % N;
    if (drop) req_a = '0;
    k = 0; clk_pos = -1; pulses = 0; acks = 0;
    while (!res_valid_a && k < 600) begin
      @(negedge clk);
      k++;
      if (adc_clk_a) begin
        pulses++;
        if (clk_pos < 0) clk_pos = k;
      end
      if (ack_a != '0) acks++;
    end
    if (!res_valid_a) begin
      chk({tag, "_valid_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_adc_clk_pos"}, clk_pos, S_A + 1);
    chk({tag, "_valid_pos"}, k, S_A + TD_A + 3);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_acks"}, acks, 0);
    chk({tag, "_res_ch"}, res_ch_a, exp_ch);
    chk({tag, "_res_data"}, res_data_a, adc_code(vin[exp_ch]));
    d0 = res_data_a; c0 = res_ch_a; unstable = 0; pulses = 0; acks = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!res_valid_a || res_data_a !== d0 || res_ch_a !== c0) unstable = 1;
      if (adc_clk_a) pulses++;
      if (ack_a != '0) acks++;
    end
    if (hold > 0) begin
      chk({tag, "_hold_stable"}, unstable, 0);
      chk({tag, "_hold_pulses"}, pulses, 0);
      chk({tag, "_hold_acks"}, acks, 0);
    end
    res_ready_a = 1'b1;
    @(negedge clk);
    chk({tag, "_released"}, res_valid_a, 0);
    chk({tag, "_idle_busy"}, busy_a, 0);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    req_a = '0;
    @(negedge clk);
    rst_a = 1'b0;
    ptr_m = 0;
  endtask

  initial begin
    int n, k, clk_pos;
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = '0; req_b = '0;
    res_ready_a = 1'b1; res_ready_b = 1'b1;
    adc_dout_a = '0; adc_dout_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack_a, 0);
    chk("rst_mux_sel", mux_sel_a, 0);
    chk("rst_adc_clk", adc_clk_a, 0);
    chk("rst_res_valid", res_valid_a, 0);
    chk("rst_res_data", res_data_a, 0);
    chk("rst_res_ch", res_ch_a, 0);
    chk("rst_busy", busy_a, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack_a != '0 || busy_a || adc_clk_a) n++;
    end
    chk("idle_no_req", n, 0);

    do_conv(4'b0001, 0, 0, "single");

    reset_a();
    for (int i = 0; i < 5; i++) do_conv(4'b1111, 0, 0, "rr");

    reset_a();
    do_conv(4'b0011, 20, 0, "bp");
    do_conv(4'b0011, 0, 0, "bp_next");

    do_conv(4'b0100, 0, 1, "drop");
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack_a != '0) n++;
    end
    chk("drop_no_more_ack", n, 0);

    req_a = 4'b0100;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_a == '0 && n < 40);
    chk("rstmid_ack", ack_a, 4'b0100);
    n = 0;
    while (!adc_clk_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_adc_clk_seen", adc_clk_a, 1);
    @(negedge clk);
    rst_a = 1'b1;
    req_a = '0;
    @(negedge clk);
    chk("rstmid_adc_clk", adc_clk_a, 0);
    chk("rstmid_res_valid", res_valid_a, 0);
    chk("rstmid_busy", busy_a, 0);
    chk("rstmid_mux_sel", mux_sel_a, 0);
    rst_a = 1'b0;
    ptr_m = 0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid_a || ack_a != '0 || adc_clk_a) n++;
    end
    chk("rstmid_quiet", n, 0);
    do_conv(4'b1001, 0, 0, "rst_ptr");
    do_conv(4'b1000, 0, 0, "rst_ch3");

    for (int i = 0; i < 16; i++) begin
      do_conv(N'($urandom_range(1, 15)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
    end

    req_b = 4'b0010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack_b == '0 && n < 40);
    chk("fast_ack", ack_b, 4'b0010);
    chk("fast_mux_sel", mux_sel_b, 1);
    req_b = '0;
    k = 0; clk_pos = -1;
    while (!res_valid_b && k < 20) begin
      @(negedge clk);
      k++;
      if (adc_clk_b && clk_pos < 0) clk_pos = k;
    end
    chk("fast_adc_clk_pos", clk_pos, 1);
    chk("fast_valid_pos", k, 3);
    chk("fast_res_ch", res_ch_b, 1);
    chk("fast_res_data", res_data_b, adc_code(vin[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
